apb_multi_slave_mem: RTL and testbench

APB_MULTI_SLAVE_MEM -- requirements
Module: apb_multi_slave_mem

---
 rtl/apb_multi_slave_mem_if.sv | 26 ++
 rtl/apb_multi_slave_mem.sv | 121 ++++++++++++
 tb/tb_apb_multi_slave_mem.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/apb_multi_slave_mem_if.sv
// APB bus bundle shared by the multi-bank register memory and its masters.
interface apb_multi_slave_mem_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int NUM_SLV = 4
);
  logic [NUM_SLV-1:0]  PSEL;
  logic                PENABLE;
  logic                PWRITE;
  logic [ADDR_W-1:0]   PADDR;
  logic [DATA_W-1:0]   PWDATA;
  logic [DATA_W/8-1:0] PSTRB;
  logic [DATA_W-1:0]   PRDATA;
  logic                PREADY;
  logic                PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_multi_slave_mem.sv
// APB slave with NUM_SLV independent word banks, optional wait states, byte strobes
// and error reporting for out-of-range, misaligned or multi-select accesses.
module apb_multi_slave_mem #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int NUM_SLV     = 4,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 0
) (
  input logic                  CLK,
  input logic                  PRESETn,
  apb_multi_slave_mem_if.slave bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int BANK_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH * 4);
  localparam logic [3:0]      WC    = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;

  state_t              state;
  logic [3:0]          cnt;
  logic [NUM_SLV-1:0]  sel_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                wr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   strb_q;

  logic [DATA_W-1:0]   mem [NUM_SLV][DEPTH];

  logic [NUM_SLV-1:0]  c_sel;
  logic [ADDR_W-1:0]   c_addr;
  logic                c_wr;
  logic [BANK_W-1:0]   c_bank;
  logic [IDX_W-1:0]    c_idx;
  logic                c_err;
  logic [DATA_W-1:0]   c_rdata;

  // In IDLE the live bus is decoded so a zero-wait transfer can complete off the
  // setup edge; afterwards only the latched setup values are used.
  always_comb begin
    c_sel  = (state == IDLE) ? bus.PSEL   : sel_q;
    c_addr = (state == IDLE) ? bus.PADDR  : addr_q;
    c_wr   = (state == IDLE) ? bus.PWRITE : wr_q;
    c_bank = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (c_sel[i]) c_bank = BANK_W'(i);
    end
    c_idx   = c_addr[IDX_W+1:2];
    c_err   = ($countones(c_sel) != 1) || ({1'b0, c_addr} >= LIMIT) || (c_addr[1:0] != 2'b00);
    c_rdata = mem[c_bank][c_idx];
  end

  always_ff @(posedge CLK) begin
    if (!PRESETn) begin
      state       <= IDLE;
      cnt         <= '0;
      sel_q       <= '0;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      strb_q      <= '0;
      bus.PREADY  <= 1'b0;
      bus.PSLVERR <= 1'b0;
      bus.PRDATA  <= '0;
      for (int unsigned b = 0; b < NUM_SLV; b++) begin
        for (int unsigned w = 0; w < DEPTH; w++) begin
          mem[b][w] <= '0;
        end
      end
    end else begin
      bus.PREADY  <= 1'b0;
      bus.PSLVERR <= 1'b0;
      bus.PRDATA  <= '0;
      unique case (state)
        IDLE: begin
          if ((|bus.PSEL) && !bus.PENABLE) begin
            sel_q   <= bus.PSEL;
            addr_q  <= bus.PADDR;
            wr_q    <= bus.PWRITE;
            wdata_q <= bus.PWDATA;
            strb_q  <= bus.PSTRB;
            if (WC == '0) begin
              state       <= READY;
              bus.PREADY  <= 1'b1;
              bus.PSLVERR <= c_err;
              bus.PRDATA  <= (c_err || c_wr) ? '0 : c_rdata;
            end else begin
              state <= WAIT;
              cnt   <= WC;
            end
          end
        end
        WAIT: begin
          if (!(|bus.PSEL) || !bus.PENABLE) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == 4'd1) begin
            state       <= READY;
            cnt         <= '0;
            bus.PREADY  <= 1'b1;
            bus.PSLVERR <= c_err;
            bus.PRDATA  <= (c_err || c_wr) ? '0 : c_rdata;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        READY: begin
          state <= IDLE;
          if (wr_q && !c_err) begin
            for (int unsigned i = 0; i < STRB_W; i++) begin
              if (strb_q[i]) mem[c_bank][c_idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_multi_slave_mem.sv
// Randomized bench for apb_multi_slave_mem: a zero-wait and a three-wait instance
// checked against an array model of the banks.
module tb_apb_multi_slave_mem;
  localparam int NS = 4;
  localparam int DP = 16;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        PRESETn;
  logic        dsel;
  logic [3:0]  psel;
  logic        penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;

  apb_multi_slave_mem_if #(.DATA_W(32), .ADDR_W(32), .NUM_SLV(NS)) bus0 ();
  apb_multi_slave_mem_if #(.DATA_W(32), .ADDR_W(32), .NUM_SLV(NS)) bus3 ();

  assign bus0.PSEL    = (dsel == 1'b0) ? psel : '0;
  assign bus0.PENABLE = penable;
  assign bus0.PWRITE  = pwrite;
  assign bus0.PADDR   = paddr;
  assign bus0.PWDATA  = pwdata;
  assign bus0.PSTRB   = pstrb;
  assign bus3.PSEL    = (dsel == 1'b1) ? psel : '0;
  assign bus3.PENABLE = penable;
  assign bus3.PWRITE  = pwrite;
  assign bus3.PADDR   = paddr;
  assign bus3.PWDATA  = pwdata;
  assign bus3.PSTRB   = pstrb;

  apb_multi_slave_mem #(.DATA_W(32), .ADDR_W(32), .NUM_SLV(NS), .DEPTH(DP), .WAIT_CYCLES(0)) u_dut0 (
    .CLK(CLK), .PRESETn(PRESETn), .bus(bus0));
  apb_multi_slave_mem #(.DATA_W(32), .ADDR_W(32), .NUM_SLV(NS), .DEPTH(DP), .WAIT_CYCLES(3)) u_dut3 (
    .CLK(CLK), .PRESETn(PRESETn), .bus(bus3));

  logic        rdy, serr;
  logic [31:0] rdat;
  assign rdy  = dsel ? bus3.PREADY  : bus0.PREADY;
  assign serr = dsel ? bus3.PSLVERR : bus0.PSLVERR;
  assign rdat = dsel ? bus3.PRDATA  : bus0.PRDATA;

  int total = 0;
  int bad   = 0;
  logic [31:0] model [2][NS][DP];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic scramble();
    paddr  = $urandom;
    pwdata = $urandom;
    pstrb  = 4'($urandom);
    pwrite = 1'($urandom_range(0, 1));
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int b = 0; b < NS; b++)
        for (int w = 0; w < DP; w++) model[d][b][w] = '0;
  endtask

  // Caller is positioned just after a rising edge; returns at the same phase
  // one edge after the READY cycle, so consecutive calls run back-to-back.
  task automatic xfer(input int which, input logic [3:0] sel, input logic wr,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rd);
    int n, b, w;
    bit got, e;
    logic [31:0] expd;
    dsel = 1'(which); psel = sel; penable = 1'b0;
    pwrite = wr; paddr = addr; pwdata = wd; pstrb = st;
    e = ($countones(sel) != 1) || (addr >= 32'd64) || (addr % 4 != 0);
    b = 0;
    for (int i = 0; i < NS; i++) if (sel[i]) b = i;
    w = e ? 0 : int'(addr / 4);
    expd = e ? 32'd0 : model[which][b][w];
    @(posedge CLK); #1;
    penable = 1'b1;
    scramble();
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(negedge CLK);
      n++;
      if (rdy) got = 1'b1;
      else begin
        chk("idle_out", {31'd0, serr, rdat}, 64'd0);
        @(posedge CLK); #1;
        scramble();
      end
    end
    rd = rdat;
    chk("latency", 64'(n), (which != 0) ? 64'd4 : 64'd1);
    chk("pslverr", {63'd0, serr}, {63'd0, e});
    if (!wr || e) chk("prdata", {32'd0, rdat}, {32'd0, expd});
    if (wr && !e && got)
      for (int i = 0; i < 4; i++)
        if (st[i]) model[which][b][w][8*i +: 8] = wd[8*i +: 8];
    @(posedge CLK); #1;
  endtask

  task automatic idle(input int n);
    psel = '0; penable = 1'b0;
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic read_all(input int which);
    logic [31:0] rd;
    for (int b = 0; b < NS; b++)
      for (int w = 0; w < DP; w++)
        xfer(which, 4'(1 << b), 1'b0, 32'(w * 4), $urandom, 4'($urandom), rd);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [3:0]  sel;
    logic [31:0] addr;
    PRESETn = 1'b0; dsel = 1'b0; psel = '0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    clear_model();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_out0", {31'd0, bus0.PREADY, bus0.PSLVERR, bus0.PRDATA}, 64'd0);
    chk("rst_out3", {31'd0, bus3.PREADY, bus3.PSLVERR, bus3.PRDATA}, 64'd0);
    @(posedge CLK); #1;

    // Setup coincides with the first edge that sees reset released.
    PRESETn = 1'b1;
    xfer(1, 4'b0001, 1'b0, 32'h04, $urandom, 4'hF, rd);
    chk("wait3_rst_read", {32'd0, rd}, 64'd0);

    xfer(0, 4'b0010, 1'b1, 32'h08, 32'hDEADBEEF, 4'hF, rd);
    xfer(0, 4'b0010, 1'b0, 32'h08, $urandom, 4'h0, rd);
    chk("deadbeef", {32'd0, rd}, 64'hDEADBEEF);

    xfer(0, 4'b0100, 1'b1, 32'h0C, 32'h11223344, 4'hF, rd);
    xfer(0, 4'b0100, 1'b1, 32'h0C, 32'hAABBCCDD, 4'h5, rd);
    xfer(0, 4'b0100, 1'b0, 32'h0C, $urandom, 4'hF, rd);
    chk("strb_merge", {32'd0, rd}, 64'h11BB33DD);
    xfer(0, 4'b0100, 1'b1, 32'h0C, $urandom, 4'h0, rd);
    xfer(0, 4'b0100, 1'b0, 32'h0C, $urandom, 4'hF, rd);
    chk("strb_zero", {32'd0, rd}, 64'h11BB33DD);

    xfer(0, 4'b0001, 1'b1, 32'h40, $urandom, 4'hF, rd);
    xfer(0, 4'b0001, 1'b1, 32'h02, $urandom, 4'hF, rd);
    xfer(0, 4'b0011, 1'b1, 32'h00, $urandom, 4'hF, rd);
    xfer(0, 4'b0001, 1'b0, 32'h40, $urandom, 4'hF, rd);
    read_all(0);

    xfer(0, 4'b0001, 1'b1, 32'h1C, 32'h0BADF00D, 4'hF, rd);
    idle(1);
    xfer(0, 4'b1000, 1'b1, 32'h1C, 32'h5A5AA5A5, 4'hF, rd);
    xfer(0, 4'b0001, 1'b0, 32'h1C, $urandom, 4'hF, rd);
    chk("b2b_bank0", {32'd0, rd}, 64'h0BADF00D);
    xfer(0, 4'b1000, 1'b0, 32'h1C, $urandom, 4'hF, rd);
    chk("b2b_bank3", {32'd0, rd}, 64'h5A5AA5A5);

    // Access phase with no preceding setup must not start a transfer.
    idle(1);
    dsel = 1'b0; psel = 4'b0001; penable = 1'b1; pwrite = 1'b1; paddr = 32'h1C; pwdata = $urandom; pstrb = 4'hF;
    repeat (3) begin
      @(negedge CLK);
      chk("no_setup_rdy", {63'd0, rdy}, 64'd0);
      @(posedge CLK); #1;
    end
    idle(1);

    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 9) == 0) sel = 4'($urandom_range(1, 15));
      else sel = 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) addr = 32'($urandom_range(0, 127));
      else addr = 32'(4 * $urandom_range(0, DP - 1));
      xfer(int'($urandom_range(0, 1)), sel, 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom), rd);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
    end

    // Abort: PSEL removed in the second wait cycle of a write.
    xfer(1, 4'b0010, 1'b1, 32'h10, 32'hCAFEF00D, 4'hF, rd);
    dsel = 1'b1; psel = 4'b0010; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = $urandom; pstrb = 4'hF;
    @(posedge CLK); #1;
    penable = 1'b1;
    @(negedge CLK);
    chk("abort_rdy_w1", {63'd0, rdy}, 64'd0);
    @(posedge CLK); #1;
    psel = '0;
    repeat (4) begin
      @(negedge CLK);
      chk("abort_rdy", {63'd0, rdy}, 64'd0);
      @(posedge CLK); #1;
    end
    idle(1);
    xfer(1, 4'b0010, 1'b0, 32'h10, $urandom, 4'hF, rd);
    chk("abort_keep", {32'd0, rd}, 64'hCAFEF00D);

    // Reset for one cycle in the middle of a waited write.
    dsel = 1'b1; psel = 4'b0100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h14; pwdata = 32'h12345678; pstrb = 4'hF;
    @(posedge CLK); #1;
    penable = 1'b1;
    @(posedge CLK); #1;
    PRESETn = 1'b0;
    @(posedge CLK); #1;
    PRESETn = 1'b1; psel = '0; penable = 1'b0;
    @(negedge CLK);
    chk("midrst_out0", {31'd0, bus0.PREADY, bus0.PSLVERR, bus0.PRDATA}, 64'd0);
    chk("midrst_out3", {31'd0, bus3.PREADY, bus3.PSLVERR, bus3.PRDATA}, 64'd0);
    clear_model();
    @(posedge CLK); #1;
    read_all(0);
    read_all(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
